// File: rtl/score_keeper.sv
// Game score/lives tracker: edge-detects start/hit/miss and runs an IDLE/PLAY/OVER game,
// keeping a saturating score, lives count and best final score for the display path.
module score_keeper #(
  parameter int MAX_SCORE  = 99,
  parameter int LIVES_INIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] lives,
  output logic       playing,
  output logic       game_over,
  output logic       win
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam logic [7:0] MAX  = 8'(MAX_SCORE);
  localparam logic [1:0] LINI = 2'(LIVES_INIT);

  logic [1:0] state, state_n;
  logic [7:0] score_n, hs_n;
  logic [1:0] lives_n;
  logic       win_n;
  logic [2:0] in_v, prev, edg;

  assign in_v = {miss, hit, start};

  // prev resets high so a level already asserted at reset release is not an edge;
  // edges are registered, so the game state reacts one clock after sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 3'b111;
      edg  <= 3'b000;
    end else begin
      prev <= in_v;
      edg  <= in_v & ~prev;
    end
  end

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    win_n   = win;
    hs_n    = high_score;
    case (state)
      IDLE, OVER: begin
        if (edg[0]) begin
          state_n = PLAY;
          score_n = 8'd0;
          lives_n = LINI;
          win_n   = 1'b0;
        end
      end
      PLAY: begin
        // hit is applied before miss, so a same-cycle win takes priority
        if (edg[1]) begin
          if (score < MAX) score_n = score + 8'd1;
          if (score_n == MAX) begin
            state_n = OVER;
            win_n   = 1'b1;
          end
        end
        if (edg[2] && lives != 2'd0) begin
          lives_n = lives - 2'd1;
          if (lives == 2'd1) state_n = OVER;
        end
        if (state_n == OVER && score_n > high_score) hs_n = score_n;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= 8'd0;
      high_score <= 8'd0;
      lives      <= 2'd0;
      win        <= 1'b0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      score      <= score_n;
      high_score <= hs_n;
      lives      <= lives_n;
      win        <= win_n;
      playing    <= (state_n == PLAY);
      game_over  <= (state_n == OVER);
    end
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter MAX_SCORE, default 99, giving the saturating score ceiling and win threshold (legal range 1..99, so the downstream two-digit BCD stage is never exceeded).
REQ-002 The block SHALL have parameter LIVES_INIT, default 3, giving the lives loaded at game start (legal range 1..3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: start/restart request level, synchronous to clk.
REQ-006 The block SHALL have port hit, input, 1 bit: point-scored level from the game logic, synchronous to clk.
REQ-007 The block SHALL have port miss, input, 1 bit: life-lost level from the game logic, synchronous to clk.
REQ-008 The block SHALL have port score, output, 8 bits: current score, binary, for the bin-to-BCD stage.
REQ-009 The block SHALL have port high_score, output, 8 bits: best final score since reset, binary.
REQ-010 The block SHALL have port lives, output, 2 bits: lives remaining.
REQ-011 The block SHALL have port playing, output, 1 bit: high while in PLAY.
REQ-012 The block SHALL have port game_over, output, 1 bit: high while in OVER.
REQ-013 The block SHALL have port win, output, 1 bit: high in OVER when the game ended by reaching MAX_SCORE.

Function
REQ-014 The block SHALL register each of start, hit and miss once (prev flops) and act only on rising edges (input=1, prev=0); an input held high SHALL count exactly once.
REQ-015 The block SHALL implement the states IDLE, PLAY and OVER, with all outputs registered.
REQ-016 In IDLE, a start edge SHALL move to PLAY, clear score to 0 and load lives=LIVES_INIT; hit and miss edges SHALL be ignored.
REQ-017 In PLAY, a hit edge SHALL increment score by 1, saturating at MAX_SCORE; start edges SHALL be ignored.
REQ-018 In PLAY, a miss edge SHALL decrement lives by 1; when lives is 1, the miss SHALL set lives to 0 and move to OVER with win=0.
REQ-019 In PLAY, a hit edge that takes score to MAX_SCORE SHALL move to OVER with win=1.
REQ-020 When hit and miss edges occur in the same cycle, the block SHALL apply the hit first and then the miss; if both would end the game, win SHALL be 1.
REQ-021 On entry to OVER, high_score SHALL become the larger of high_score and the final score, including any hit applied in the same cycle.
REQ-022 In OVER, score, lives and win SHALL hold; a start edge SHALL restart exactly as in REQ-016 and clear win.
REQ-023 Latency: an edge sampled at clock edge N SHALL be visible on every affected output after clock edge N+1 (two-register path: the prev flop, then the state/counter flop).
REQ-024 score SHALL never exceed MAX_SCORE, and lives SHALL never underflow below 0.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force state=IDLE, score=0, high_score=0, lives=0, playing=0, game_over=0 and win=0.
REQ-026 Reset SHALL force the prev flops to 1, so an input already high when reset is released generates no edge.
REQ-027 Reset asserted mid-game SHALL abandon the game without updating high_score.
REQ-028 Release of rst_n SHALL take effect synchronously, with the first state change no earlier than the second rising clk edge after release.

Verification
REQ-029 The bench SHALL cover: reset, then a start pulse, then 5 hit pulses -> playing=1, score=5, lives=3.
REQ-030 The bench SHALL cover: hit held high for 10 cycles in PLAY -> score increments by exactly 1.
REQ-031 The bench SHALL cover: 3 miss pulses after 7 hits -> lives 3,2,1,0; game_over=1, win=0, high_score=7; further hits leave score=7.
REQ-032 The bench SHALL cover: MAX_SCORE=4, with 4 hits -> game_over=1, win=1, score=4, high_score=4; a further start -> score=0, lives=3, win=0.
REQ-033 The bench SHALL cover: lives=1 with simultaneous hit and miss at score 2 -> score=3, lives=0, OVER, high_score updated to 3 if it was below 3.
REQ-034 The bench SHALL cover: rst_n asserted mid-PLAY at score 9 -> all outputs 0 immediately; start held high across reset release -> block stays in IDLE.
